// File: rtl/debug_uart_rx_pkg.sv
// Shared definitions for the debug UART: receiver FSM states and bit-timing helpers.
package debug_uart_rx_pkg;

  // Receiver FSM states; BREAK holds while the line stays low after a bad stop bit.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

  // Number of system clocks per serial bit.
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Half a bit period, used to land the first sample in the middle of the start bit.
  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/debug_uart_rx_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to 1 so an idle-high line
// does not look like a start bit while coming out of reset.
module debug_uart_rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // Two register stages per bit to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= '1;
      sync_reg <= '1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/debug_uart_rx.sv
// 8N1 UART receiver with a one-entry holding register and sticky overrun / framing flags.
module debug_uart_rx
  import debug_uart_rx_pkg::*;
#(
  parameter int CLK_HZ   = 14_000_000,
  parameter int BIT_RATE = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  input  logic       uart_rx_read,
  input  logic       uart_rx_err_clr,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_valid,
  output logic       uart_rx_busy,
  output logic       uart_rx_overrun,
  output logic       uart_rx_frame_err
);

  localparam int CPB  = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int HALF = half_bit(CPB);
  localparam int CW   = $clog2(CPB);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);

  logic rxd_s;

  uart_state_t   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tick;
  logic          deliver;
  logic          frame_set;

  logic [7:0] data_reg;
  logic       valid_reg;
  logic       overrun_reg;
  logic       frame_err_reg;

  debug_uart_rx_sync #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rxd),
    .q   (rxd_s)
  );

  assign tick = (cnt_reg == '0);

  // FSM, bit-period counter, bit index and shift register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
    end
  end

  // Next-state logic: sample mid-bit on each counter tick, deliver or flag at the stop bit.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    deliver    = 1'b0;
    frame_set  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!rxd_s) begin
          state_next = START;
          cnt_next   = CNT_HALF;
        end
      end
      START: begin
        if (tick) begin
          if (!rxd_s) begin
            state_next = DATA;
            cnt_next   = CNT_FULL;
            idx_next   = '0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          shift_next = {rxd_s, shift_reg[7:1]};
          cnt_next   = CNT_FULL;
          if (idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          if (rxd_s) begin
            deliver    = 1'b1;
            state_next = IDLE;
          end else begin
            frame_set  = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      BREAK: begin
        if (rxd_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Holding register and sticky flags; a flag set outranks a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg      <= 8'h00;
      valid_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (deliver) begin
        data_reg  <= shift_reg;
        valid_reg <= 1'b1;
      end else if (uart_rx_read) begin
        valid_reg <= 1'b0;
      end

      if (deliver && valid_reg && !uart_rx_read) begin
        overrun_reg <= 1'b1;
      end else if (uart_rx_err_clr) begin
        overrun_reg <= 1'b0;
      end

      if (frame_set) begin
        frame_err_reg <= 1'b1;
      end else if (uart_rx_err_clr) begin
        frame_err_reg <= 1'b0;
      end
    end
  end

  assign uart_rx_data      = data_reg;
  assign uart_rx_valid     = valid_reg;
  assign uart_rx_busy      = (state_reg != IDLE);
  assign uart_rx_overrun   = overrun_reg;
  assign uart_rx_frame_err = frame_err_reg;

endmodule

// File: tb/tb_debug_uart_rx.sv
// Directed testbench for debug_uart_rx at 14 clocks per bit.
module tb_debug_uart_rx;

  localparam int CPB = 14;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rxd;
  logic       uart_rx_read;
  logic       uart_rx_err_clr;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       uart_rx_busy;
  logic       uart_rx_overrun;
  logic       uart_rx_frame_err;

  int n_compared   = 0;
  int n_mismatched = 0;
  int valid_rises  = 0;
  logic valid_q    = 1'b0;

  debug_uart_rx #(
    .CLK_HZ   (14_000_000),
    .BIT_RATE (1_000_000)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .uart_rxd          (uart_rxd),
    .uart_rx_read      (uart_rx_read),
    .uart_rx_err_clr   (uart_rx_err_clr),
    .uart_rx_data      (uart_rx_data),
    .uart_rx_valid     (uart_rx_valid),
    .uart_rx_busy      (uart_rx_busy),
    .uart_rx_overrun   (uart_rx_overrun),
    .uart_rx_frame_err (uart_rx_frame_err)
  );

  always #5 clk = ~clk;

  // Count rising edges of valid, sampled away from the active edge.
  always @(negedge clk) begin
    if (uart_rx_valid === 1'b1 && valid_q === 1'b0) valid_rises++;
    valid_q = uart_rx_valid;
  end

  // Serial frame, LSB first; called and returns on a falling clock edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    $display("tx byte 0x%02h stop=%0b  rx data=0x%02h valid=%0b ovr=%0b ferr=%0b",
             b, stop_bit, uart_rx_data, uart_rx_valid, uart_rx_overrun, uart_rx_frame_err);
  endtask

  task automatic pulse_read();
    uart_rx_read = 1'b1;
    @(negedge clk);
    uart_rx_read = 1'b0;
  endtask

  task automatic pulse_err_clr();
    uart_rx_err_clr = 1'b1;
    @(negedge clk);
    uart_rx_err_clr = 1'b0;
  endtask

  task automatic wait_valid(output logic ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 400) begin
      if (uart_rx_valid === 1'b1) ok = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; uart_rxd = 1'b1; uart_rx_read = 1'b0; uart_rx_err_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_compared++;
    if ({uart_rx_data, uart_rx_valid, uart_rx_busy, uart_rx_overrun, uart_rx_frame_err} !== 12'h000) begin
      n_mismatched++;
      $display("FAIL reset_outputs: got data=%02h v=%0b b=%0b o=%0b f=%0b, want all 0",
               uart_rx_data, uart_rx_valid, uart_rx_busy, uart_rx_overrun, uart_rx_frame_err);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_compared++;
    if (uart_rx_busy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL idle_busy: got %0b want 0", uart_rx_busy);
    end
    $display("reset done");
  endtask

  task automatic test_single_byte();
    int rises0;
    rises0 = valid_rises;
    send_byte(8'hA5, 1'b1);
    repeat (3) @(negedge clk);
    n_compared++;
    if (uart_rx_data !== 8'hA5) begin
      n_mismatched++; $display("FAIL t1_data: got %02h want a5", uart_rx_data);
    end
    n_compared++;
    if (valid_rises - rises0 !== 1) begin
      n_mismatched++; $display("FAIL t1_valid_rises: got %0d want 1", valid_rises - rises0);
    end
    n_compared++;
    if ({uart_rx_valid, uart_rx_busy, uart_rx_overrun, uart_rx_frame_err} !== 4'b1000) begin
      n_mismatched++;
      $display("FAIL t1_status: got v=%0b b=%0b o=%0b f=%0b want v=1 b=0 o=0 f=0",
               uart_rx_valid, uart_rx_busy, uart_rx_overrun, uart_rx_frame_err);
    end
    pulse_read();
    n_compared++;
    if (uart_rx_valid !== 1'b0) begin
      n_mismatched++; $display("FAIL t1_read_clears: got %0b want 0", uart_rx_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [2];
    exp_b[0] = 8'h00;
    exp_b[1] = 8'hFF;
    fork
      begin
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          logic ok;
          wait_valid(ok);
          n_compared++;
          if (ok !== 1'b1) begin
            n_mismatched++; $display("FAIL t2_timeout byte %0d: valid got 0 want 1", k);
          end
          n_compared++;
          if (uart_rx_data !== exp_b[k]) begin
            n_mismatched++;
            $display("FAIL t2_data byte %0d: got %02h want %02h", k, uart_rx_data, exp_b[k]);
          end
          pulse_read();
        end
      end
    join
    repeat (3) @(negedge clk);
    n_compared++;
    if ({uart_rx_valid, uart_rx_overrun, uart_rx_frame_err} !== 3'b000) begin
      n_mismatched++;
      $display("FAIL t2_flags: got v=%0b o=%0b f=%0b want 000",
               uart_rx_valid, uart_rx_overrun, uart_rx_frame_err);
    end
  endtask

  task automatic test_overrun();
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    n_compared++;
    if ({uart_rx_data, uart_rx_valid, uart_rx_overrun} !== {8'hC3, 1'b1, 1'b1}) begin
      n_mismatched++;
      $display("FAIL t3_overrun: got data=%02h v=%0b o=%0b want c3 1 1",
               uart_rx_data, uart_rx_valid, uart_rx_overrun);
    end
    pulse_err_clr();
    n_compared++;
    if ({uart_rx_valid, uart_rx_overrun} !== 2'b10) begin
      n_mismatched++;
      $display("FAIL t3_err_clr: got v=%0b o=%0b want v=1 o=0", uart_rx_valid, uart_rx_overrun);
    end
    pulse_read();
  endtask

  task automatic test_frame_error();
    send_byte(8'h96, 1'b0);
    uart_rxd = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    n_compared++;
    if ({uart_rx_frame_err, uart_rx_valid, uart_rx_busy} !== 3'b101) begin
      n_mismatched++;
      $display("FAIL t4_break: got f=%0b v=%0b b=%0b want f=1 v=0 b=1",
               uart_rx_frame_err, uart_rx_valid, uart_rx_busy);
    end
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk);
    n_compared++;
    if (uart_rx_busy !== 1'b0) begin
      n_mismatched++; $display("FAIL t4_break_exit: busy got %0b want 0", uart_rx_busy);
    end
    send_byte(8'h55, 1'b1);
    n_compared++;
    if ({uart_rx_data, uart_rx_valid, uart_rx_frame_err} !== {8'h55, 1'b1, 1'b1}) begin
      n_mismatched++;
      $display("FAIL t4_recover: got data=%02h v=%0b f=%0b want 55 1 1",
               uart_rx_data, uart_rx_valid, uart_rx_frame_err);
    end
    pulse_err_clr();
    pulse_read();
    n_compared++;
    if ({uart_rx_valid, uart_rx_frame_err} !== 2'b00) begin
      n_mismatched++;
      $display("FAIL t4_clear: got v=%0b f=%0b want 00", uart_rx_valid, uart_rx_frame_err);
    end
  endtask

  task automatic test_glitch();
    int rises0;
    rises0 = valid_rises;
    uart_rxd = 1'b0;
    repeat (5) @(negedge clk);
    n_compared++;
    if (uart_rx_busy !== 1'b1) begin
      n_mismatched++; $display("FAIL t5_start_seen: busy got %0b want 1", uart_rx_busy);
    end
    uart_rxd = 1'b1;
    repeat (30) @(negedge clk);
    n_compared++;
    if ({uart_rx_busy, uart_rx_valid, uart_rx_overrun, uart_rx_frame_err} !== 4'b0000
        || valid_rises != rises0) begin
      n_mismatched++;
      $display("FAIL t5_glitch: got b=%0b v=%0b o=%0b f=%0b rises=%0d want all 0, no rise",
               uart_rx_busy, uart_rx_valid, uart_rx_overrun, uart_rx_frame_err,
               valid_rises - rises0);
    end
    $display("glitch of 5 cycles driven");
  endtask

  task automatic test_reset_mid_frame();
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_compared++;
    if (uart_rx_busy !== 1'b1) begin
      n_mismatched++; $display("FAIL t6_in_frame: busy got %0b want 1", uart_rx_busy);
    end
    #2 rst = 1'b1;
    #1;
    n_compared++;
    if ({uart_rx_data, uart_rx_valid, uart_rx_busy, uart_rx_overrun, uart_rx_frame_err} !== 12'h000) begin
      n_mismatched++;
      $display("FAIL t6_async_reset: got data=%02h v=%0b b=%0b o=%0b f=%0b want all 0",
               uart_rx_data, uart_rx_valid, uart_rx_busy, uart_rx_overrun, uart_rx_frame_err);
    end
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_byte(8'h81, 1'b1);
    n_compared++;
    if ({uart_rx_data, uart_rx_valid, uart_rx_overrun, uart_rx_frame_err} !== {8'h81, 3'b100}) begin
      n_mismatched++;
      $display("FAIL t6_after_reset: got data=%02h v=%0b o=%0b f=%0b want 81 1 0 0",
               uart_rx_data, uart_rx_valid, uart_rx_overrun, uart_rx_frame_err);
    end
    // Deliver lands on the 136th rising edge after the start edge; read covers exactly that edge.
    fork
      send_byte(8'h7E, 1'b1);
      begin
        repeat (135) @(negedge clk);
        pulse_read();
      end
    join
    n_compared++;
    if ({uart_rx_data, uart_rx_valid, uart_rx_overrun} !== {8'h7E, 1'b1, 1'b0}) begin
      n_mismatched++;
      $display("FAIL t6_read_on_deliver: got data=%02h v=%0b o=%0b want 7e 1 0",
               uart_rx_data, uart_rx_valid, uart_rx_overrun);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
